bpf_multi_dispatch: RTL and testbench

- Sits between one packet snooper/forwarder pair and N_VMS bpfvm instances in the packet filter top level. Replaces the single-VM direct wiring.
- Ingress: steers each whole incoming packet to a ready VM, round-robin. When no VM is ready, it drops the packet and counts the drop for the Status register.
- Egress: grants the forwarder to one finished VM at a time, round-robin, and muxes that VM's read data and length back.

---
 rtl/bpf_multi_dispatch.sv | 188 ++++++++++++++++++
 tb/tb_bpf_multi_dispatch.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpf_multi_dispatch.sv
// Fans one snooper/forwarder pair out to N_VMS bpfvm instances: whole packets are
// steered round-robin to ready VMs on ingress, and finished VMs are granted the forwarder in turn.
module bpf_multi_dispatch #(
  parameter int N_VMS                  = 4,
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int SNOOP_FWD_ADDR_WIDTH   = 9,
  localparam int DW = 2**(3+PACKET_BYTE_ADDR_WIDTH-SNOOP_FWD_ADDR_WIDTH),
  localparam int LW = SNOOP_FWD_ADDR_WIDTH+1,
  localparam int AW = SNOOP_FWD_ADDR_WIDTH
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [AW-1:0]       snooper_wr_addr,
  input  logic [DW-1:0]       snooper_wr_data,
  input  logic                snooper_wr_en,
  input  logic                snooper_done,
  output logic                ready_for_snooper,
  input  logic [AW-1:0]       forwarder_rd_addr,
  input  logic                forwarder_rd_en,
  input  logic                forwarder_done,
  output logic [DW-1:0]       forwarder_rd_data,
  output logic                ready_for_forwarder,
  output logic [LW-1:0]       len_to_forwarder,
  output logic [AW-1:0]       vm_snooper_wr_addr,
  output logic [DW-1:0]       vm_snooper_wr_data,
  output logic [N_VMS-1:0]    vm_snooper_wr_en,
  output logic [N_VMS-1:0]    vm_snooper_done,
  input  logic [N_VMS-1:0]    vm_ready_for_snooper,
  output logic [AW-1:0]       vm_forwarder_rd_addr,
  output logic [N_VMS-1:0]    vm_forwarder_rd_en,
  output logic [N_VMS-1:0]    vm_forwarder_done,
  input  logic [N_VMS*DW-1:0] vm_forwarder_rd_data,
  input  logic [N_VMS-1:0]    vm_ready_for_forwarder,
  input  logic [N_VMS*LW-1:0] vm_len_to_forwarder,
  input  logic                drop_cnt_clear,
  output logic [15:0]         num_packets_dropped
);

  localparam int PW = $clog2(N_VMS);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} snoop_state_e;
  typedef enum logic       {F_IDLE, F_BUSY}        fwd_state_e;

  snoop_state_e   r_snoop_state, w_snoop_state_nxt;
  logic [PW-1:0]  r_snoop_sel, w_snoop_sel_nxt;
  logic [PW-1:0]  r_snoop_ptr, w_snoop_ptr_nxt;
  fwd_state_e     r_fwd_state, w_fwd_state_nxt;
  logic [PW-1:0]  r_fwd_sel, w_fwd_sel_nxt;
  logic [PW-1:0]  r_fwd_ptr, w_fwd_ptr_nxt;
  logic [15:0]    r_drop_cnt;
  logic           w_drop_inc;
  logic [PW-1:0]  w_snoop_pick, w_fwd_pick;

  // First requester at or after ptr, wrapping past N_VMS-1 back to 0.
  function automatic logic [PW-1:0] rr_pick(input logic [N_VMS-1:0] req,
                                            input logic [PW-1:0]    ptr);
    logic [PW-1:0] pick;
    logic          found;
    logic [PW:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_VMS; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_VMS)) idx = idx - (PW+1)'(N_VMS);
      if (!found && req[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] sel);
    return (sel == PW'(N_VMS-1)) ? '0 : sel + 1'b1;
  endfunction

  assign w_snoop_pick         = rr_pick(vm_ready_for_snooper, r_snoop_ptr);
  assign w_fwd_pick           = rr_pick(vm_ready_for_forwarder, r_fwd_ptr);
  assign vm_snooper_wr_addr   = snooper_wr_addr;
  assign vm_snooper_wr_data   = snooper_wr_data;
  assign vm_forwarder_rd_addr = forwarder_rd_addr;
  assign num_packets_dropped  = r_drop_cnt;
  assign ready_for_forwarder  = (r_fwd_state == F_BUSY);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_snoop_state_nxt = r_snoop_state;
    w_snoop_sel_nxt   = r_snoop_sel;
    w_snoop_ptr_nxt   = r_snoop_ptr;
    w_drop_inc        = 1'b0;
    vm_snooper_wr_en  = '0;
    vm_snooper_done   = '0;
    ready_for_snooper = 1'b1;
    unique case (r_snoop_state)
      S_IDLE: begin
        ready_for_snooper = |vm_ready_for_snooper;
        if (snooper_wr_en) begin
          if (|vm_ready_for_snooper) begin
            vm_snooper_wr_en[w_snoop_pick] = 1'b1;
            vm_snooper_done[w_snoop_pick]  = snooper_done;
            w_snoop_sel_nxt                = w_snoop_pick;
            w_snoop_ptr_nxt                = next_idx(w_snoop_pick);
            if (!snooper_done) w_snoop_state_nxt = S_FWD;
          end else if (snooper_done) begin
            w_drop_inc = 1'b1;
          end else begin
            w_snoop_state_nxt = S_DROP;
          end
        end
      end
      S_FWD: begin
        vm_snooper_wr_en[r_snoop_sel] = snooper_wr_en;
        vm_snooper_done[r_snoop_sel]  = snooper_done;
        if (snooper_done) w_snoop_state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (snooper_done) begin
          w_drop_inc        = 1'b1;
          w_snoop_state_nxt = S_IDLE;
        end
      end
      default: w_snoop_state_nxt = S_IDLE;
    endcase
    // Nothing reaches a VM while reset is held, so an aborted packet never sees a done.
    if (!axi_aresetn) begin
      vm_snooper_wr_en = '0;
      vm_snooper_done  = '0;
    end
  end

  always_comb begin
    w_fwd_state_nxt    = r_fwd_state;
    w_fwd_sel_nxt      = r_fwd_sel;
    w_fwd_ptr_nxt      = r_fwd_ptr;
    vm_forwarder_rd_en = '0;
    vm_forwarder_done  = '0;
    forwarder_rd_data  = '0;
    len_to_forwarder   = '0;
    unique case (r_fwd_state)
      F_IDLE: begin
        if (|vm_ready_for_forwarder) begin
          w_fwd_sel_nxt   = w_fwd_pick;
          w_fwd_state_nxt = F_BUSY;
        end
      end
      F_BUSY: begin
        vm_forwarder_rd_en[r_fwd_sel] = forwarder_rd_en;
        forwarder_rd_data = vm_forwarder_rd_data[r_fwd_sel*DW +: DW];
        len_to_forwarder  = vm_len_to_forwarder[r_fwd_sel*LW +: LW];
        if (forwarder_done) begin
          vm_forwarder_done[r_fwd_sel] = 1'b1;
          w_fwd_ptr_nxt                = next_idx(r_fwd_sel);
          w_fwd_state_nxt              = F_IDLE;
        end
      end
      default: w_fwd_state_nxt = F_IDLE;
    endcase
    if (!axi_aresetn) begin
      vm_forwarder_rd_en = '0;
      vm_forwarder_done  = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_snoop_state <= S_IDLE;
      r_snoop_sel   <= '0;
      r_snoop_ptr   <= '0;
      r_fwd_state   <= F_IDLE;
      r_fwd_sel     <= '0;
      r_fwd_ptr     <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_snoop_state <= w_snoop_state_nxt;
      r_snoop_sel   <= w_snoop_sel_nxt;
      r_snoop_ptr   <= w_snoop_ptr_nxt;
      r_fwd_state   <= w_fwd_state_nxt;
      r_fwd_sel     <= w_fwd_sel_nxt;
      r_fwd_ptr     <= w_fwd_ptr_nxt;
      if (drop_cnt_clear)
        r_drop_cnt <= w_drop_inc ? 16'd1 : 16'd0;
      else if (w_drop_inc && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bpf_multi_dispatch.sv
// Directed bench for bpf_multi_dispatch with N_VMS=4: round-robin ingress, drops and
// saturation, egress grant order, reset mid-packet and concurrent ingress/egress.
module tb_bpf_multi_dispatch;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int LW = 10;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [AW-1:0]   snooper_wr_addr;
  logic [DW-1:0]   snooper_wr_data;
  logic            snooper_wr_en, snooper_done;
  logic            ready_for_snooper;
  logic [AW-1:0]   forwarder_rd_addr;
  logic            forwarder_rd_en, forwarder_done;
  logic [DW-1:0]   forwarder_rd_data;
  logic            ready_for_forwarder;
  logic [LW-1:0]   len_to_forwarder;
  logic [AW-1:0]   vm_snooper_wr_addr;
  logic [DW-1:0]   vm_snooper_wr_data;
  logic [N-1:0]    vm_snooper_wr_en, vm_snooper_done, vm_ready_for_snooper;
  logic [AW-1:0]   vm_forwarder_rd_addr;
  logic [N-1:0]    vm_forwarder_rd_en, vm_forwarder_done, vm_ready_for_forwarder;
  logic [N*DW-1:0] vm_forwarder_rd_data;
  logic [N*LW-1:0] vm_len_to_forwarder;
  logic            drop_cnt_clear;
  logic [15:0]     num_packets_dropped;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bpf_multi_dispatch dut (
    .axi_aclk(clk), .axi_aresetn(aresetn),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .forwarder_rd_addr(forwarder_rd_addr), .forwarder_rd_en(forwarder_rd_en),
    .forwarder_done(forwarder_done), .forwarder_rd_data(forwarder_rd_data),
    .ready_for_forwarder(ready_for_forwarder), .len_to_forwarder(len_to_forwarder),
    .vm_snooper_wr_addr(vm_snooper_wr_addr), .vm_snooper_wr_data(vm_snooper_wr_data),
    .vm_snooper_wr_en(vm_snooper_wr_en), .vm_snooper_done(vm_snooper_done),
    .vm_ready_for_snooper(vm_ready_for_snooper),
    .vm_forwarder_rd_addr(vm_forwarder_rd_addr), .vm_forwarder_rd_en(vm_forwarder_rd_en),
    .vm_forwarder_done(vm_forwarder_done), .vm_forwarder_rd_data(vm_forwarder_rd_data),
    .vm_ready_for_forwarder(vm_ready_for_forwarder), .vm_len_to_forwarder(vm_len_to_forwarder),
    .drop_cnt_clear(drop_cnt_clear), .num_packets_dropped(num_packets_dropped)
  );

  // Inputs change 1 ns after a rising edge; checks happen 1 ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    snooper_wr_en = 1'b0; snooper_done = 1'b0;
    forwarder_rd_en = 1'b0; forwarder_done = 1'b0; drop_cnt_clear = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    vm_ready_for_snooper = 4'b0000;
    do_reset();
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b0 || vm_snooper_done !== 4'b0 ||
        vm_forwarder_rd_en !== 4'b0 || vm_forwarder_done !== 4'b0) begin
      errors++;
      $display("FAIL reset_onehot: wr_en=%b sdone=%b rd_en=%b fdone=%b, required all 0",
               vm_snooper_wr_en, vm_snooper_done, vm_forwarder_rd_en, vm_forwarder_done);
    end
    checks++;
    if (ready_for_forwarder !== 1'b0 || forwarder_rd_data !== '0 || len_to_forwarder !== '0) begin
      errors++;
      $display("FAIL reset_fwd_outputs: rdy=%b data=%h len=%0d, required 0/0/0",
               ready_for_forwarder, forwarder_rd_data, len_to_forwarder);
    end
    checks++;
    if (num_packets_dropped !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d, required 0", num_packets_dropped);
    end
    checks++;
    if (ready_for_snooper !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_snoop_none: got %b, required 0", ready_for_snooper);
    end
    vm_ready_for_snooper = 4'b0010;
    #1;
    checks++;
    if (ready_for_snooper !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_snoop_one: got %b, required 1", ready_for_snooper);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    vm_ready_for_snooper = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      exp = 4'b0001 << (p % 4);
      for (int w = 0; w < 3; w++) begin
        snooper_wr_en   = 1'b1;
        snooper_wr_addr = AW'(p*8 + w);
        snooper_wr_data = 64'hD000_0000_0000_0000 | 64'(p*16 + w);
        #1;
        checks++;
        if (vm_snooper_wr_en !== exp || vm_snooper_done !== 4'b0) begin
          errors++;
          $display("FAIL rr_wr_en p%0d w%0d: wr_en=%b done=%b, required wr_en=%b done=0000",
                   p, w, vm_snooper_wr_en, vm_snooper_done, exp);
        end
        checks++;
        if (vm_snooper_wr_addr !== snooper_wr_addr || vm_snooper_wr_data !== snooper_wr_data) begin
          errors++;
          $display("FAIL rr_broadcast p%0d w%0d: addr=%h data=%h, required %h %h", p, w,
                   vm_snooper_wr_addr, vm_snooper_wr_data, snooper_wr_addr, snooper_wr_data);
        end
        tick();
      end
      snooper_wr_en = 1'b0;
      snooper_done  = 1'b1;
      #1;
      checks++;
      if (vm_snooper_done !== exp || vm_snooper_wr_en !== 4'b0) begin
        errors++;
        $display("FAIL rr_done p%0d: done=%b wr_en=%b, required done=%b wr_en=0000",
                 p, vm_snooper_done, vm_snooper_wr_en, exp);
      end
      tick();
      snooper_done = 1'b0;
    end
  endtask

  task automatic test_skip_busy();
    do_reset();
    vm_ready_for_snooper = 4'b0100;
    snooper_wr_en = 1'b1;
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b0100) begin
      errors++;
      $display("FAIL skip_busy_target: wr_en=%b, required 0100", vm_snooper_wr_en);
    end
    tick();
    // VM2 drops its ready mid-packet; the packet stays on VM2 and the dispatcher stays ready.
    vm_ready_for_snooper = 4'b0000;
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b0100 || ready_for_snooper !== 1'b1) begin
      errors++;
      $display("FAIL skip_busy_hold: wr_en=%b rdy=%b, required 0100 1",
               vm_snooper_wr_en, ready_for_snooper);
    end
    snooper_wr_en = 1'b0; snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    // Pointer is now 3: a single-word packet lands on VM3 with both strobes together.
    vm_ready_for_snooper = 4'b1111;
    snooper_wr_en = 1'b1; snooper_done = 1'b1;
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b1000 || vm_snooper_done !== 4'b1000) begin
      errors++;
      $display("FAIL single_word: wr_en=%b done=%b, required 1000 1000",
               vm_snooper_wr_en, vm_snooper_done);
    end
    tick();
    snooper_done = 1'b0;
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b0001) begin
      errors++;
      $display("FAIL ptr_wrap: wr_en=%b, required 0001", vm_snooper_wr_en);
    end
    snooper_wr_en = 1'b0; snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
  endtask

  task automatic test_drop();
    vm_ready_for_snooper = 4'b0000;
    #1;
    checks++;
    if (ready_for_snooper !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle_rdy: got %b, required 0", ready_for_snooper);
    end
    for (int p = 0; p < 3; p++) begin
      snooper_wr_en = 1'b1;
      tick();
      #1;
      checks++;
      if (vm_snooper_wr_en !== 4'b0 || ready_for_snooper !== 1'b1) begin
        errors++;
        $display("FAIL drop_swallow p%0d: wr_en=%b rdy=%b, required 0000 1",
                 p, vm_snooper_wr_en, ready_for_snooper);
      end
      snooper_wr_en = 1'b0; snooper_done = 1'b1;
      #1;
      checks++;
      if (vm_snooper_done !== 4'b0) begin
        errors++;
        $display("FAIL drop_done p%0d: done=%b, required 0000", p, vm_snooper_done);
      end
      tick();
      snooper_done = 1'b0;
    end
    checks++;
    if (num_packets_dropped !== 16'd3) begin
      errors++;
      $display("FAIL drop_count3: got %0d, required 3", num_packets_dropped);
    end
    snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    checks++;
    if (num_packets_dropped !== 16'd3) begin
      errors++;
      $display("FAIL idle_done_ignored: got %0d, required 3", num_packets_dropped);
    end
    drop_cnt_clear = 1'b1;
    tick();
    drop_cnt_clear = 1'b0;
    checks++;
    if (num_packets_dropped !== 16'd0) begin
      errors++;
      $display("FAIL clear_alone: got %0d, required 0", num_packets_dropped);
    end
    snooper_wr_en = 1'b1; snooper_done = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    snooper_wr_en = 1'b0; snooper_done = 1'b0;
    checks++;
    if (num_packets_dropped !== 16'hFFFE) begin
      errors++;
      $display("FAIL drop_fffe: got %h, required fffe", num_packets_dropped);
    end
    snooper_wr_en = 1'b1; snooper_done = 1'b1;
    tick(); tick();
    snooper_wr_en = 1'b0; snooper_done = 1'b0;
    checks++;
    if (num_packets_dropped !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate: got %h, required ffff", num_packets_dropped);
    end
    snooper_wr_en = 1'b1;
    tick();
    snooper_wr_en = 1'b0; snooper_done = 1'b1; drop_cnt_clear = 1'b1;
    tick();
    snooper_done = 1'b0; drop_cnt_clear = 1'b0;
    checks++;
    if (num_packets_dropped !== 16'd1) begin
      errors++;
      $display("FAIL clear_with_drop: got %0d, required 1", num_packets_dropped);
    end
  endtask

  task automatic test_egress();
    do_reset();
    for (int i = 0; i < N; i++)
      vm_forwarder_rd_data[i*DW +: DW] = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
    vm_len_to_forwarder = {10'd60, 10'd9, 10'd42, 10'd7};
    vm_ready_for_forwarder = 4'b0000;
    forwarder_done = 1'b1;
    #1;
    checks++;
    if (vm_forwarder_done !== 4'b0 || ready_for_forwarder !== 1'b0) begin
      errors++;
      $display("FAIL fwd_idle_done: done=%b rdy=%b, required 0000 0",
               vm_forwarder_done, ready_for_forwarder);
    end
    tick();
    forwarder_done = 1'b0;
    vm_ready_for_forwarder = 4'b1010;
    #1;
    checks++;
    if (ready_for_forwarder !== 1'b0) begin
      errors++;
      $display("FAIL grant_latency: rdy=%b same cycle, required 0", ready_for_forwarder);
    end
    tick();
    checks++;
    if (ready_for_forwarder !== 1'b1 || len_to_forwarder !== 10'd42 ||
        forwarder_rd_data !== 64'hA5A5_0000_0000_0002) begin
      errors++;
      $display("FAIL grant_vm1: rdy=%b len=%0d data=%h, required 1 42 a5a5000000000002",
               ready_for_forwarder, len_to_forwarder, forwarder_rd_data);
    end
    forwarder_rd_en = 1'b1; forwarder_rd_addr = 9'h155;
    #1;
    checks++;
    if (vm_forwarder_rd_en !== 4'b0010 || vm_forwarder_rd_addr !== 9'h155) begin
      errors++;
      $display("FAIL rd_en_vm1: rd_en=%b addr=%h, required 0010 155",
               vm_forwarder_rd_en, vm_forwarder_rd_addr);
    end
    tick();
    forwarder_rd_en = 1'b0; forwarder_done = 1'b1;
    #1;
    checks++;
    if (vm_forwarder_done !== 4'b0010) begin
      errors++;
      $display("FAIL done_vm1: done=%b, required 0010", vm_forwarder_done);
    end
    tick();
    forwarder_done = 1'b0;
    checks++;
    if (ready_for_forwarder !== 1'b0) begin
      errors++;
      $display("FAIL no_regrant_on_done: rdy=%b, required 0", ready_for_forwarder);
    end
    tick();
    checks++;
    if (ready_for_forwarder !== 1'b1 || len_to_forwarder !== 10'd60 ||
        forwarder_rd_data !== 64'hA5A5_0000_0000_0004) begin
      errors++;
      $display("FAIL grant_vm3: rdy=%b len=%0d data=%h, required 1 60 a5a5000000000004",
               ready_for_forwarder, len_to_forwarder, forwarder_rd_data);
    end
    forwarder_done = 1'b1;
    #1;
    checks++;
    if (vm_forwarder_done !== 4'b1000) begin
      errors++;
      $display("FAIL done_vm3: done=%b, required 1000", vm_forwarder_done);
    end
    tick();
    forwarder_done = 1'b0;
    vm_ready_for_forwarder = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    vm_ready_for_snooper = 4'b1111;
    snooper_wr_en = 1'b1; snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b0010) begin
      errors++;
      $display("FAIL mid_first_write: wr_en=%b, required 0010", vm_snooper_wr_en);
    end
    tick();
    aresetn = 1'b0;
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_gated: wr_en=%b, required 0000", vm_snooper_wr_en);
    end
    tick();
    aresetn = 1'b1; snooper_wr_en = 1'b0; snooper_done = 1'b1;
    #1;
    checks++;
    if (vm_snooper_done !== 4'b0 || ready_for_forwarder !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: done=%b rdy_fwd=%b, required 0000 0",
               vm_snooper_done, ready_for_forwarder);
    end
    tick();
    snooper_done = 1'b0; snooper_wr_en = 1'b1;
    #1;
    checks++;
    if (vm_snooper_wr_en !== 4'b0001) begin
      errors++;
      $display("FAIL mid_restart_vm0: wr_en=%b, required 0001", vm_snooper_wr_en);
    end
    tick();
    snooper_wr_en = 1'b0; snooper_done = 1'b1;
    tick();
    snooper_done = 1'b0;
  endtask

  task automatic test_concurrent();
    do_reset();
    vm_ready_for_snooper   = 4'b0100;
    vm_ready_for_forwarder = 4'b0001;
    tick();
    for (int w = 0; w < 3; w++) begin
      snooper_wr_en = 1'b1; forwarder_rd_en = 1'b1;
      #1;
      checks++;
      if (vm_snooper_wr_en !== 4'b0100 || vm_forwarder_rd_en !== 4'b0001) begin
        errors++;
        $display("FAIL concurrent_en w%0d: wr_en=%b rd_en=%b, required 0100 0001",
                 w, vm_snooper_wr_en, vm_forwarder_rd_en);
      end
      tick();
    end
    snooper_wr_en = 1'b0; forwarder_rd_en = 1'b0;
    snooper_done = 1'b1; forwarder_done = 1'b1;
    #1;
    checks++;
    if (vm_snooper_done !== 4'b0100 || vm_forwarder_done !== 4'b0001) begin
      errors++;
      $display("FAIL concurrent_done: sdone=%b fdone=%b, required 0100 0001",
               vm_snooper_done, vm_forwarder_done);
    end
    tick();
    snooper_done = 1'b0; forwarder_done = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    snooper_wr_addr = '0; snooper_wr_data = '0;
    snooper_wr_en = 1'b0; snooper_done = 1'b0;
    forwarder_rd_addr = '0; forwarder_rd_en = 1'b0; forwarder_done = 1'b0;
    vm_ready_for_snooper = '0; vm_ready_for_forwarder = '0;
    vm_forwarder_rd_data = '0; vm_len_to_forwarder = '0;
    drop_cnt_clear = 1'b0;
    test_reset();
    test_round_robin();
    test_skip_busy();
    test_drop();
    test_egress();
    test_reset_mid_packet();
    test_concurrent();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
